fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the EX-stage operand selectors.
- Drives the 2-bit select of the two 3:1 ALU operand muxes (A and B).
- Select encoding: 00 = register-file value, 01 = MEM/WB result, 10 = EX/MEM result.
- Keeps its own shadow pipeline of destination info for the EX, MEM and WB slots, and raises a one-cycle stall on load-use hazards.

Parameters:
- REG_AW, 5: register address width. Register 0 is hard-wired zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  ID source register A.
- id_rt  in  REG_AW  ID source register B.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_dest  in  REG_AW  ID destination register.
- id_regwrite  in  1  ID instruction writes id_dest.
- id_memread  in  1  ID instruction is a load.
- flush  in  1  branch/jump flush; ID instruction is squashed.
- ex_fwd_a_sel  out  2  registered select for the operand-A mux.
- ex_fwd_b_sel  out  2  registered select for the operand-B mux.
- stall  out  1  hold PC and IF/ID this cycle; combinational.

Behaviour:
- Reset is asynchronous and active-low; clock is clk, reset is rst_n.
- Shadow slots EX, MEM, WB each hold {vld, dest, regwrite, memread}.
- While rst_n=0: all slots vld=0, ex_fwd_a_sel=ex_fwd_b_sel=00, stall=0. An assertion mid-operation clears everything immediately; stall drops in the same cycle.
- Match(slot, r) = slot.vld & slot.regwrite & (slot.dest==r) & (r!=0).
- Hazard = EX.memread & ((id_uses_rs & Match(EX,id_rs)) | (id_uses_rt & Match(EX,id_rt))) & id_valid.
- stall = hazard & !flush. Flush wins over stall when both occur.
- Select for source r (evaluated in ID, registered into EX, so latency is 1 cycle):
  - if uses_r & Match(EX,r): 10
  - else if uses_r & Match(MEM,r): 01
  - else: 00
  - EX/MEM beats MEM/WB when both match.
- Select 11 is never produced.
- Each rising edge:
  - WB <= MEM; MEM <= EX.
  - If stall | flush | !id_valid: EX <= bubble (vld=0) and both sel outputs <= 00.
  - Otherwise: EX <= {1, id_dest, id_regwrite, id_memread}; sel outputs <= computed values.
- WB slot is not a forwarding source: the register file writes before it reads. The slot exists only so the optional counters can observe retirement.
- Load-use sequence:
  - Cycle t: stall=1.
  - Cycle t+1: the load is in MEM, the consumer is re-evaluated in ID, and the sel is registered as 01.
- Back-to-back loads hitting the same consumer: each stall lasts exactly one cycle and is never extended.
- Register 0 is never forwarded or stalled on, even if a producer writes it.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined, adds three ports:
  - perf_clr  in  1  synchronous clear of both counters.
  - stall_cnt  out  32  cycles with stall=1.
  - fwd_cnt  out  32  EX entries whose sel A or sel B is non-zero.
- Both counters reset to 0 on rst_n and saturate at all-ones.
- When perf_clr and an increment coincide, clear wins.
- When not defined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_MEMWB=2'b01, FWD_EXMEM=2'b10.
  - A slot struct typedef {vld, dest, regwrite, memread}.
  - REG_AW default.
- One natural sub-module, fwd_sel_calc: combinational select calculation for a single source operand, instantiated twice (A and B).

Test Plan:
- Reset: hold rst_n=0, drive id_valid=1 with a hazard pattern -> sels=00, stall=0. Release rst_n -> first edge loads EX normally.
- EX/MEM forward: add r3 then sub reading rs=r3 on the next cycle -> ex_fwd_a_sel=10 in the sub's EX cycle, stall never asserted.
- Priority: writes to r5 in two consecutive instructions, then a reader with rt=r5 -> ex_fwd_b_sel=10, not 01.
- Load-use: lw r7 followed by add reading rs=r7 -> stall=1 for exactly one cycle, one bubble, then ex_fwd_a_sel=01.
- Flush with hazard: same lw/add pair with flush=1 in the stall cycle -> stall=0, EX receives a bubble, sels=00.
- Zero register: producer with dest r0 and reader rs=r0 -> sel=00. Also a load to r0 -> no stall. With FWD_HAZARD_PERF_EN defined: the load-use case gives stall_cnt=1, and perf_clr returns both counters to 0.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl_pkg
// Description : Shared types, select encodings and slot-match helper for the
//               EX-stage forwarding / load-use hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_hazard_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    // Slot width is fixed here; the top REG_AW must not exceed REG_AW_DEFAULT.
    typedef struct packed {
        logic                      vld;
        logic [REG_AW_DEFAULT-1:0] dest;
        logic                      regwrite;
        logic                      memread;
    } slot_t;

    function automatic logic slot_match(input slot_t s, input logic [REG_AW_DEFAULT-1:0] r);
        return s.vld & s.regwrite & (s.dest == r) & (r != '0);
    endfunction

endpackage : fwd_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl_if
// Description : ID-stage instruction info in, operand selects and stall out.
//               Perf ports exist only when FWD_HAZARD_PERF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_dest;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic [1:0]        ex_fwd_a_sel;
    logic [1:0]        ex_fwd_b_sel;
    logic              stall;
`ifdef FWD_HAZARD_PERF_EN
    logic              perf_clr;
    logic [31:0]       stall_cnt;
    logic [31:0]       fwd_cnt;
`endif

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
        output id_dest, id_regwrite, id_memread, flush,
`ifdef FWD_HAZARD_PERF_EN
        output perf_clr,
        input  stall_cnt, fwd_cnt,
`endif
        input  ex_fwd_a_sel, ex_fwd_b_sel, stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  id_dest, id_regwrite, id_memread, flush,
`ifdef FWD_HAZARD_PERF_EN
        input  perf_clr,
        output stall_cnt, fwd_cnt,
`endif
        output ex_fwd_a_sel, ex_fwd_b_sel, stall
    );

endinterface : fwd_hazard_ctrl_if
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_fwd_sel_calc.sv
`default_nettype none
// ============================================================================
// Module      : fwd_sel_calc
// Description : Combinational forwarding select for one source operand.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel_calc
    import fwd_hazard_ctrl_pkg::*;
(
    input  wire logic                      uses,
    input  wire logic [REG_AW_DEFAULT-1:0] src,
    input  wire slot_t                     ex_slot,
    input  wire slot_t                     mem_slot,
    output logic [1:0]                     sel
);

    // The youngest producer (EX) wins when both EX and MEM write the register.
    always_comb begin
        sel = FWD_RF;
        if (uses && slot_match(ex_slot, src)) begin
            sel = FWD_EXMEM;
        end else if (uses && slot_match(mem_slot, src)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule : fwd_sel_calc
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : EX-stage forwarding select and load-use stall controller with
//               an internal EX/MEM/WB shadow pipeline. Optional perf counters
//               are enabled by defining FWD_HAZARD_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fwd_hazard_ctrl_if.slave bus
);

    localparam slot_t C_BUBBLE = '{vld: 1'b0, dest: '0, regwrite: 1'b0, memread: 1'b0};

    slot_t                     r_ex;
    slot_t                     r_mem;
    slot_t                     r_wb;
    logic [1:0]                r_sel_a;
    logic [1:0]                r_sel_b;

    logic [REG_AW_DEFAULT-1:0] w_rs;
    logic [REG_AW_DEFAULT-1:0] w_rt;
    logic [REG_AW_DEFAULT-1:0] w_dest;
    logic [1:0]                w_sel_a;
    logic [1:0]                w_sel_b;
    logic                      w_hazard;
    logic                      w_stall;
    logic                      w_load;

    assign w_rs   = REG_AW_DEFAULT'(bus.id_rs);
    assign w_rt   = REG_AW_DEFAULT'(bus.id_rt);
    assign w_dest = REG_AW_DEFAULT'(bus.id_dest);

    fwd_sel_calc u_sel_a (
        .uses     (bus.id_uses_rs),
        .src      (w_rs),
        .ex_slot  (r_ex),
        .mem_slot (r_mem),
        .sel      (w_sel_a)
    );

    fwd_sel_calc u_sel_b (
        .uses     (bus.id_uses_rt),
        .src      (w_rt),
        .ex_slot  (r_ex),
        .mem_slot (r_mem),
        .sel      (w_sel_b)
    );

    // A load in EX cannot forward yet; the consumer must wait one cycle.
    assign w_hazard = r_ex.memread & bus.id_valid &
                      ((bus.id_uses_rs & slot_match(r_ex, w_rs)) |
                       (bus.id_uses_rt & slot_match(r_ex, w_rt)));
    assign w_stall  = w_hazard & ~bus.flush;
    assign w_load   = bus.id_valid & ~w_stall & ~bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= C_BUBBLE;
            r_mem   <= C_BUBBLE;
            r_wb    <= C_BUBBLE;
            r_sel_a <= FWD_RF;
            r_sel_b <= FWD_RF;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_load) begin
                r_ex    <= '{vld: 1'b1, dest: w_dest,
                             regwrite: bus.id_regwrite, memread: bus.id_memread};
                r_sel_a <= w_sel_a;
                r_sel_b <= w_sel_b;
            end else begin
                r_ex    <= C_BUBBLE;
                r_sel_a <= FWD_RF;
                r_sel_b <= FWD_RF;
            end
        end
    end

    assign bus.ex_fwd_a_sel = r_sel_a;
    assign bus.ex_fwd_b_sel = r_sel_b;
    assign bus.stall        = w_stall;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;
    logic        w_fwd_inc;

    assign w_fwd_inc = w_load & ((w_sel_a != FWD_RF) | (w_sel_b != FWD_RF));

    // Clear has priority over increment; both counters saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (bus.perf_clr) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_fwd_inc && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.fwd_cnt   = r_fwd_cnt;
`endif

endmodule : fwd_hazard_ctrl
`default_nettype wire
